// File: rtl/cnt_cmd_dispatcher.sv
// cnt_cmd_dispatcher: queues count commands in a small FIFO and hands them,
// one at a time and in acceptance order, to a downstream counter FSM using
// its idle/done handshake.
// Optional feature macro: CMD_SKIP_ZERO_EN -- when defined, zero-count head
// entries are dropped in S_IDLE instead of being dispatched.
module cnt_cmd_dispatcher #(
  parameter int DEPTH = 4,
  parameter int CW    = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [CW-1:0]          i_cmd_num,
  input  logic                   i_dn_idle,
  input  logic                   i_dn_done,
  output logic                   o_run,
  output logic [CW-1:0]          o_num_cnt,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_fifo_cnt,
  output logic [15:0]            o_jobs_done
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   head;
  logic            has_cmd, head_zero, push, pop, pop_skip, pop_issue;

  assign o_cmd_ready = (count != FULL_CNT);
  assign o_fifo_cnt  = count;
  assign push        = i_cmd_valid & o_cmd_ready;
  assign head        = mem[rd_ptr];
  assign has_cmd     = (count != '0);

`ifdef CMD_SKIP_ZERO_EN
  assign head_zero = (head == '0);
`else
  assign head_zero = 1'b0;
`endif

  // Zero heads drain without waiting for downstream; real jobs need it idle.
  assign pop_skip  = (state == S_IDLE) && has_cmd && head_zero;
  assign pop_issue = (state == S_IDLE) && has_cmd && !head_zero && i_dn_idle;
  assign pop       = pop_skip | pop_issue;

  // Storage is not reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_cmd_num;
  end

  // FIFO pointers and occupancy; push and pop on one edge cancel out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Dispatch FSM with registered run/busy/count outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      o_run       <= 1'b0;
      o_busy      <= 1'b0;
      o_num_cnt   <= '0;
      o_jobs_done <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_issue) begin
            state     <= S_ISSUE;
            o_num_cnt <= head;
            o_run     <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          o_run <= 1'b0;
        end
        S_WAIT: begin
          if (i_dn_done) begin
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_jobs_done <= o_jobs_done + 16'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_run  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_cmd_dispatcher.sv
// Bench for cnt_cmd_dispatcher: scoreboard of expected dispatch counts,
// popped and compared whenever o_run is observed.
module tb_cnt_cmd_dispatcher;
  localparam int DEPTH = 4;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic [CW-1:0] i_cmd_num = '0;
  logic          i_dn_idle = 1'b0;
  logic          i_dn_done = 1'b0;
  logic          o_cmd_ready, o_run, o_busy;
  logic [CW-1:0] o_num_cnt;
  logic [2:0]    o_fifo_cnt;
  logic [15:0]   o_jobs_done;

  int   checks = 0;
  int   errors = 0;
  int   runs = 0;
  int   exp_jobs = 0;
  logic prev_run = 1'b0;
  logic [CW-1:0] sb [$];

  cnt_cmd_dispatcher #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd_num(i_cmd_num),
    .i_dn_idle(i_dn_idle), .i_dn_done(i_dn_done), .o_run(o_run),
    .o_num_cnt(o_num_cnt), .o_busy(o_busy), .o_fifo_cnt(o_fifo_cnt),
    .o_jobs_done(o_jobs_done)
  );

  always #5 clk = ~clk;

  function automatic bit dispatchable(input logic [CW-1:0] v);
`ifdef CMD_SKIP_ZERO_EN
    return v != '0;
`else
    return 1'b1;
`endif
  endfunction

  // Advance one cycle, then check any o_run against the scoreboard.
  task automatic tick();
    logic [CW-1:0] exp;
    @(posedge clk); #1;
    if (o_run === 1'b1) begin
      runs++;
      checks++;
      if (prev_run) begin
        errors++; $display("FAIL run_width: o_run high for a second cycle");
      end else if (sb.size() == 0) begin
        errors++; $display("FAIL unexpected_run: o_num_cnt=%0d, no dispatch expected", o_num_cnt);
      end else begin
        exp = sb.pop_front();
        if (o_num_cnt !== exp) begin
          errors++; $display("FAIL dispatch_order: o_num_cnt=%0d expected %0d", o_num_cnt, exp);
        end
      end
    end
    prev_run = (o_run === 1'b1);
  endtask

  task automatic push(input logic [CW-1:0] v);
    i_cmd_valid = 1'b1; i_cmd_num = v;
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL push_ready: o_cmd_ready=%b expected 1", o_cmd_ready);
    end
    tick();
    i_cmd_valid = 1'b0;
    if (dispatchable(v)) sb.push_back(v);
  endtask

  task automatic wait_run();
    int n = 0;
    while (o_run !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (o_run !== 1'b1) begin
      errors++; $display("FAIL run_timeout: o_run=%b expected 1 within 30 cycles", o_run);
    end
  endtask

  task automatic finish_job();
    i_dn_done = 1'b1;
    tick();
    i_dn_done = 1'b0; i_dn_idle = 1'b1;
    exp_jobs++;
    checks++;
    if (o_jobs_done !== 16'(exp_jobs) || o_busy !== 1'b0) begin
      errors++; $display("FAIL job_done: jobs=%0d busy=%b expected %0d/0", o_jobs_done, o_busy, exp_jobs);
    end
  endtask

  task automatic run_job();
    wait_run();
    i_dn_idle = 1'b0;
    tick(); tick();
    finish_job();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if (o_run !== 1'b0 || o_busy !== 1'b0 || o_num_cnt !== '0 ||
        o_fifo_cnt !== 3'd0 || o_jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: run=%b busy=%b num=%0d fifo=%0d jobs=%0d expected all 0",
               o_run, o_busy, o_num_cnt, o_fifo_cnt, o_jobs_done);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: o_cmd_ready=%b expected 1", o_cmd_ready);
    end
  endtask

  task automatic test_single();
    i_dn_idle = 1'b1;
    push(7'd100);
    checks++;
    if (o_run !== 1'b0 || o_fifo_cnt !== 3'd1) begin
      errors++; $display("FAIL latency_t: run=%b fifo=%0d expected 0/1", o_run, o_fifo_cnt);
    end
    tick();
    checks++;
    if (o_run !== 1'b1 || o_num_cnt !== 7'd100 || o_busy !== 1'b1 || o_fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL latency_t1: run=%b num=%0d busy=%b fifo=%0d expected 1/100/1/0",
               o_run, o_num_cnt, o_busy, o_fifo_cnt);
    end
    i_dn_idle = 1'b0;
    tick(); tick();
    checks++;
    if (o_run !== 1'b0 || o_busy !== 1'b1 || o_num_cnt !== 7'd100) begin
      errors++; $display("FAIL wait_hold: run=%b busy=%b num=%0d expected 0/1/100", o_run, o_busy, o_num_cnt);
    end
    finish_job();
  endtask

  task automatic test_backpressure();
    i_dn_idle = 1'b0;
    push(7'd10); push(7'd20); push(7'd30); push(7'd40);
    i_cmd_valid = 1'b1; i_cmd_num = 7'd50;
    checks++;
    if (o_cmd_ready !== 1'b0 || o_fifo_cnt !== 3'd4) begin
      errors++; $display("FAIL full: ready=%b fifo=%0d expected 0/4", o_cmd_ready, o_fifo_cnt);
    end
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_fifo_cnt !== 3'd4) begin
      errors++; $display("FAIL no_overwrite: fifo=%0d expected 4", o_fifo_cnt);
    end
    i_dn_idle = 1'b1;
    repeat (4) run_job();
    checks++;
    if (sb.size() != 0 || o_fifo_cnt !== 3'd0) begin
      errors++; $display("FAIL drain: pending=%0d fifo=%0d expected 0/0", sb.size(), o_fifo_cnt);
    end
  endtask

  task automatic test_gating();
    int r0;
    i_dn_idle = 1'b0;
    push(7'd55);
    r0 = runs;
    repeat (20) tick();
    checks++;
    if (runs != r0) begin
      errors++; $display("FAIL gating: runs=%0d expected %0d", runs, r0);
    end
    i_dn_idle = 1'b1;
    tick();
    checks++;
    if (o_run !== 1'b1) begin
      errors++; $display("FAIL gate_release: o_run=%b expected 1", o_run);
    end
    i_dn_idle = 1'b0;
    tick(); tick();
    finish_job();
  endtask

  task automatic test_spurious_done();
    i_dn_done = 1'b1;
    tick(); tick();
    i_dn_done = 1'b0;
    checks++;
    if (o_jobs_done !== 16'(exp_jobs) || o_busy !== 1'b0 || o_run !== 1'b0) begin
      errors++; $display("FAIL done_in_idle: jobs=%0d busy=%b run=%b expected %0d/0/0",
                         o_jobs_done, o_busy, o_run, exp_jobs);
    end
    i_dn_idle = 1'b1;
    push(7'd66);
    i_dn_done = 1'b1;
    tick(); tick();
    i_dn_done = 1'b0; i_dn_idle = 1'b0;
    checks++;
    if (o_jobs_done !== 16'(exp_jobs) || o_busy !== 1'b1) begin
      errors++; $display("FAIL done_in_issue: jobs=%0d busy=%b expected %0d/1", o_jobs_done, o_busy, exp_jobs);
    end
    tick();
    finish_job();
  endtask

  task automatic test_back_to_back();
    i_dn_idle = 1'b1;
    push(7'd1);
    push(7'd2);
    checks++;
    if (o_fifo_cnt !== 3'd1 || o_run !== 1'b1) begin
      errors++; $display("FAIL push_pop: fifo=%0d run=%b expected 1/1", o_fifo_cnt, o_run);
    end
    run_job();
    run_job();
  endtask

  task automatic test_zero();
    int r0, n;
`ifdef CMD_SKIP_ZERO_EN
    n = 1;
`else
    n = 2;
`endif
    r0 = runs;
    i_dn_idle = 1'b1;
    push(7'd0);
    push(7'd7);
    repeat (n) run_job();
    repeat (3) tick();
    checks++;
    if (runs - r0 != n || sb.size() != 0) begin
      errors++; $display("FAIL zero_count: runs=%0d expected %0d", runs - r0, n);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    i_dn_idle = 1'b1;
    push(7'd11);
    wait_run();
    i_dn_idle = 1'b0;
    push(7'd12); push(7'd13); push(7'd14);
    checks++;
    if (o_fifo_cnt !== 3'd3 || o_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset: fifo=%0d busy=%b expected 3/1", o_fifo_cnt, o_busy);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    sb.delete();
    exp_jobs = 0;
    checks++;
    if (o_fifo_cnt !== 3'd0 || o_jobs_done !== 16'd0 || o_busy !== 1'b0 || o_run !== 1'b0) begin
      errors++; $display("FAIL mid_reset: fifo=%0d jobs=%0d busy=%b run=%b expected 0/0/0/0",
                         o_fifo_cnt, o_jobs_done, o_busy, o_run);
    end
    r0 = runs;
    i_dn_idle = 1'b1;
    repeat (10) tick();
    checks++;
    if (runs != r0) begin
      errors++; $display("FAIL post_reset_run: runs=%0d expected %0d", runs, r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_gating();
    test_spurious_done();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
